uart_word_tx: RTL and testbench
===============================

Name: uart_word_tx

Overview:
- Word-to-byte serializer between the CPU subsystem and the UART0 transmit path.
- Accepts one NB_DATA-bit word per handshake and writes it into the UART TX FIFO as NB_DATA/NB_UART_DATA bytes.
- After the last byte it pulses tx_start, then counts per-byte tx_done pulses until the whole word has left the line.
- It is the transmit-direction counterpart of the byte-to-word receive path: the CPU sends results or debug words without per-byte software handling.

Parameters:
- NB_DATA, 32: width of the input word; must be an integer multiple of NB_UART_DATA.
- NB_UART_DATA, 8: UART byte width.
- LSB_FIRST, 1: 1 sends byte 0 (bits [7:0]) first; 0 sends the MSB byte first.
- NB_TIMEOUT, 24: width of the per-byte watchdog counter.

Ports:
- clk  in  1  system clock (PLL output domain).
- i_rst  in  1  reset, asynchronous, active-low.
- i_word  in  NB_DATA  word to transmit.
- i_valid  in  1  word present on i_word.
- o_ready  out  1  block idle; the word is accepted on the cycle where i_valid && o_ready.
- o_done  out  1  one-cycle pulse when all bytes of the word have been transmitted.
- o_error  out  1  one-cycle pulse on watchdog expiry.
- i_timeout_cmp  in  NB_TIMEOUT  maximum cycles between tx_done pulses; 0 disables the watchdog.
- o_uart_wr  out  1  one-cycle write strobe into the UART TX FIFO.
- o_uart_wdata  out  NB_UART_DATA  byte being written; valid while o_uart_wr is high.
- o_uart_tx_start  out  1  one-cycle pulse that starts UART transmission.
- i_uart_tx_full  in  1  UART TX FIFO full.
- i_uart_tx_done  in  1  one-cycle pulse per byte fully shifted out.

Behaviour:
- Reset (i_rst low, asynchronous): state IDLE, o_ready=1, all strobes 0, o_uart_wdata=0, byte and done counters 0, watchdog 0.
- Reset mid-operation aborts immediately: no o_done, no o_error, FIFO contents are left to UART0.
- N = NB_DATA/NB_UART_DATA. Byte index counter width is clog2(N)+1. The tx_done counter uses the same width.
- IDLE: o_ready=1.
  - On i_valid: latch i_word into a shift register, clear counters, go to LOAD.
  - o_ready drops in the cycle after acceptance.
- LOAD: each cycle with i_uart_tx_full=0, assert o_uart_wr=1 and drive o_uart_wdata with the current byte.
  - The current byte is the low byte if LOAD_FIRST... i.e. if LSB_FIRST=1, otherwise the high byte.
  - After each write, shift the register by NB_UART_DATA and increment the byte index.
  - If i_uart_tx_full=1: o_uart_wr=0 and the byte is held; the stall is unbounded.
  - Back-to-back writes are allowed, so N bytes take N cycles when the FIFO is never full.
  - After byte N-1 is written, go to START.
- START: o_uart_tx_start=1 for exactly one cycle, reset the watchdog, go to WAIT.
  - Latency from acceptance to the tx_start pulse is N+1 cycles minimum.
- WAIT: each i_uart_tx_done pulse increments the done counter and reloads the watchdog.
  - When the counter reaches N: pulse o_done in the next cycle and return to IDLE.
  - o_ready=1 in the cycle after o_done.
- Watchdog, WAIT only:
  - Counts cycles since the last tx_done (or since tx_start); it does not run in LOAD.
  - If i_timeout_cmp!=0 and the count equals i_timeout_cmp: pulse o_error, return to IDLE, no o_done.
  - The watchdog saturates and does not wrap.
- i_uart_tx_done outside WAIT is ignored; this covers stale pulses from a previous word.
- A tx_done arriving in the same cycle as watchdog expiry counts as the event: reload, no error.
- i_valid while not ready is ignored; there is no queuing, and the caller holds i_valid.
- o_done and o_error are mutually exclusive per word.

Decomposition:
- Shared package (uart_pkg): FSM state encoding (IDLE, LOAD, START, WAIT) and the localparam for bytes per word.
- No sub-module; the watchdog is a counter inside the block.

Test Plan:
- Basic send, LSB_FIRST=1:
  - Stimulus: i_word=32'hDEADBEEF, FIFO never full, tx_done pulses 10 cycles apart.
  - Response: wdata sequence EF,BE,AD,DE on 4 consecutive cycles; tx_start 1 cycle later; o_done one cycle after the 4th tx_done; o_ready=1 the next cycle.
- Byte order, LSB_FIRST=0:
  - Stimulus: i_word=32'h01020304.
  - Response: wdata sequence 01,02,03,04.
- FIFO backpressure:
  - Stimulus: i_uart_tx_full=1 for 5 cycles after the 2nd byte.
  - Response: no o_uart_wr during the stall; byte 3 is held stable and written the cycle after full drops; exactly 4 writes in total.
- Watchdog:
  - Stimulus: i_timeout_cmp=100, only 2 tx_done pulses arrive.
  - Response: o_error pulses 100 cycles after the 2nd tx_done, no o_done, returns to IDLE.
  - Repeat with i_timeout_cmp=0: the block waits forever.
- Reset mid-LOAD:
  - Stimulus: assert i_rst low after 2 writes.
  - Response: all outputs return to reset values immediately; after release the next word sends all 4 bytes from byte 0.
- Handshake edges:
  - Stimulus: i_valid held through a transfer, plus a stray tx_done pulse in IDLE.
  - Response: the second word is accepted only the cycle after o_done; the stray pulse does not affect the next word's count.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the word-to-byte UART transmit path:
// FSM encoding, default geometry and bytes-per-word helper.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT
    } state_t;

    localparam int DEF_NB_DATA      = 32;
    localparam int DEF_NB_UART_DATA = 8;

    function automatic int bytes_per_word(input int nb_data, input int nb_byte);
        return nb_data / nb_byte;
    endfunction

    localparam int BYTES_PER_WORD = bytes_per_word(DEF_NB_DATA, DEF_NB_UART_DATA);

endpackage

// File: rtl/uart_word_tx.sv
// Serializes one NB_DATA word into the UART TX FIFO byte by byte, starts the
// transmission and waits for every byte's tx_done under a per-byte watchdog.
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int NB_DATA      = DEF_NB_DATA,
    parameter int NB_UART_DATA = DEF_NB_UART_DATA,
    parameter int LSB_FIRST    = 1,
    parameter int NB_TIMEOUT   = 24
) (
    input  logic                    clk,
    input  logic                    i_rst,
    input  logic [NB_DATA-1:0]      i_word,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic                    o_done,
    output logic                    o_error,
    input  logic [NB_TIMEOUT-1:0]   i_timeout_cmp,
    output logic                    o_uart_wr,
    output logic [NB_UART_DATA-1:0] o_uart_wdata,
    output logic                    o_uart_tx_start,
    input  logic                    i_uart_tx_full,
    input  logic                    i_uart_tx_done
);

    localparam int N      = bytes_per_word(NB_DATA, NB_UART_DATA);
    localparam int NB_CNT = $clog2(N) + 1;

    localparam logic [NB_CNT-1:0]     LAST_BYTE = NB_CNT'(N - 1);
    localparam logic [NB_CNT-1:0]     ALL_DONE  = NB_CNT'(N);
    localparam logic [NB_TIMEOUT-1:0] WDOG_MAX  = {NB_TIMEOUT{1'b1}};

    state_t                  state_reg, state_next;
    logic [NB_DATA-1:0]      shift_reg, shift_next;
    logic [NB_CNT-1:0]       byte_cnt_reg, byte_cnt_next;
    logic [NB_CNT-1:0]       done_cnt_reg, done_cnt_next;
    logic [NB_TIMEOUT-1:0]   wdog_reg, wdog_next;

    logic [NB_UART_DATA-1:0] cur_byte;
    logic [NB_DATA-1:0]      shift_adv;

    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign cur_byte  = shift_reg[NB_UART_DATA-1:0];
            assign shift_adv = shift_reg >> NB_UART_DATA;
        end else begin : g_msb_first
            assign cur_byte  = shift_reg[NB_DATA-1 -: NB_UART_DATA];
            assign shift_adv = shift_reg << NB_UART_DATA;
        end
    endgenerate

    // The shift register clears on reset, so the byte lane idles at zero.
    assign o_uart_wdata = cur_byte;

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg    <= ST_IDLE;
            shift_reg    <= '0;
            byte_cnt_reg <= '0;
            done_cnt_reg <= '0;
            wdog_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            byte_cnt_reg <= byte_cnt_next;
            done_cnt_reg <= done_cnt_next;
            wdog_reg     <= wdog_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        byte_cnt_next   = byte_cnt_reg;
        done_cnt_next   = done_cnt_reg;
        wdog_next       = wdog_reg;
        o_ready         = 1'b0;
        o_uart_wr       = 1'b0;
        o_uart_tx_start = 1'b0;
        o_done          = 1'b0;
        o_error         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    shift_next    = i_word;
                    byte_cnt_next = '0;
                    done_cnt_next = '0;
                    wdog_next     = '0;
                    state_next    = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (!i_uart_tx_full) begin
                    o_uart_wr     = 1'b1;
                    shift_next    = shift_adv;
                    byte_cnt_next = byte_cnt_reg + NB_CNT'(1);
                    if (byte_cnt_reg == LAST_BYTE) begin
                        state_next = ST_START;
                    end
                end
            end

            ST_START: begin
                o_uart_tx_start = 1'b1;
                // Watchdog value is the number of cycles elapsed since the
                // last event, so the first WAIT cycle already reads 1.
                wdog_next       = NB_TIMEOUT'(1);
                state_next      = ST_WAIT;
            end

            ST_WAIT: begin
                if (done_cnt_reg == ALL_DONE) begin
                    o_done     = 1'b1;
                    state_next = ST_IDLE;
                end else if (i_uart_tx_done) begin
                    // A tx_done coinciding with expiry wins over the error.
                    done_cnt_next = done_cnt_reg + NB_CNT'(1);
                    wdog_next     = NB_TIMEOUT'(1);
                end else if ((i_timeout_cmp != '0) && (wdog_reg == i_timeout_cmp)) begin
                    o_error    = 1'b1;
                    state_next = ST_IDLE;
                end else if (wdog_reg != WDOG_MAX) begin
                    wdog_next = wdog_reg + NB_TIMEOUT'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Scoreboard bench for uart_word_tx: LSB-first and MSB-first instances share
// stimulus; expected bytes are queued on acceptance and popped on each write.
`timescale 1ns/1ps
module tb_uart_word_tx;
    import uart_pkg::*;

    localparam int NB_DATA = 32;
    localparam int NB_UD   = 8;
    localparam int NB_TO   = 24;
    localparam int N       = BYTES_PER_WORD;

    logic               clk = 1'b0;
    logic               i_rst = 1'b0;
    logic [NB_DATA-1:0] i_word = '0;
    logic               i_valid = 1'b0;
    logic [NB_TO-1:0]   i_timeout_cmp = '0;
    logic               i_uart_tx_full = 1'b0;
    logic               i_uart_tx_done = 1'b0;

    logic             ready_l, done_l, err_l, wr_l, start_l;
    logic [NB_UD-1:0] wdata_l;
    logic             ready_m, done_m, err_m, wr_m, start_m;
    logic [NB_UD-1:0] wdata_m;

    always #5 clk = ~clk;

    uart_word_tx #(.NB_DATA(NB_DATA), .NB_UART_DATA(NB_UD), .LSB_FIRST(1), .NB_TIMEOUT(NB_TO)) dut_lsb (
        .clk(clk), .i_rst(i_rst), .i_word(i_word), .i_valid(i_valid),
        .o_ready(ready_l), .o_done(done_l), .o_error(err_l),
        .i_timeout_cmp(i_timeout_cmp), .o_uart_wr(wr_l), .o_uart_wdata(wdata_l),
        .o_uart_tx_start(start_l), .i_uart_tx_full(i_uart_tx_full),
        .i_uart_tx_done(i_uart_tx_done)
    );

    uart_word_tx #(.NB_DATA(NB_DATA), .NB_UART_DATA(NB_UD), .LSB_FIRST(0), .NB_TIMEOUT(NB_TO)) dut_msb (
        .clk(clk), .i_rst(i_rst), .i_word(i_word), .i_valid(i_valid),
        .o_ready(ready_m), .o_done(done_m), .o_error(err_m),
        .i_timeout_cmp(i_timeout_cmp), .o_uart_wr(wr_m), .o_uart_wdata(wdata_m),
        .o_uart_tx_start(start_m), .i_uart_tx_full(i_uart_tx_full),
        .i_uart_tx_done(i_uart_tx_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [NB_UD-1:0] q_lsb[$];
    logic [NB_UD-1:0] q_msb[$];
    int wr_log[$];
    int cyc = 0;
    int acc_cnt = 0, wr_cnt = 0, start_cnt = 0, done_cnt = 0, err_cnt = 0;
    int acc_cyc = 0, start_cyc = 0, done_cyc = 0, err_cyc = 0, txd_cyc = 0;
    logic done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!i_rst) begin
            q_lsb.delete();
            q_msb.delete();
            done_prev = 1'b0;
        end else begin
            check("ctrl_sync", {28'd0, ready_m, start_m, done_m, err_m},
                               {28'd0, ready_l, start_l, done_l, err_l});
            if (i_uart_tx_full) begin
                check("wr_while_full", {31'd0, wr_l}, 32'd0);
                if (q_lsb.size() > 0) check("held_byte", {24'd0, wdata_l}, {24'd0, q_lsb[0]});
            end
            if (wr_l || wr_m) begin
                check("wr_sync", {31'd0, wr_m}, {31'd0, wr_l});
                wr_cnt++;
                wr_log.push_back(cyc);
                check("lsb_expected_byte", {31'd0, q_lsb.size() > 0}, 32'd1);
                if (q_lsb.size() > 0) check("lsb_byte", {24'd0, wdata_l}, {24'd0, q_lsb.pop_front()});
                check("msb_expected_byte", {31'd0, q_msb.size() > 0}, 32'd1);
                if (q_msb.size() > 0) check("msb_byte", {24'd0, wdata_m}, {24'd0, q_msb.pop_front()});
                $display("[TB] cycle %0d write lsb=%02h msb=%02h", cyc, wdata_l, wdata_m);
            end
            if (done_prev) check("ready_after_done", {31'd0, ready_l}, 32'd1);
            if (done_l) begin
                check("ready_during_done", {31'd0, ready_l}, 32'd0);
                done_cnt++;
                done_cyc = cyc;
                $display("[TB] cycle %0d word done", cyc);
            end
            done_prev = done_l;
            if (start_l) begin
                start_cnt++;
                start_cyc = cyc;
            end
            if (err_l) begin
                err_cnt++;
                err_cyc = cyc;
                $display("[TB] cycle %0d watchdog error", cyc);
            end
            if (i_uart_tx_done) txd_cyc = cyc;
            if (i_valid && ready_l) begin
                acc_cnt++;
                acc_cyc = cyc;
                for (int i = 0; i < N; i++) begin
                    q_lsb.push_back(i_word[NB_UD*i +: NB_UD]);
                    q_msb.push_back(i_word[NB_UD*(N-1-i) +: NB_UD]);
                end
                $display("[TB] cycle %0d accepted word %08h", cyc, i_word);
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic int get_cnt(input int which);
        case (which)
            0:       return acc_cnt;
            1:       return start_cnt;
            2:       return done_cnt;
            3:       return err_cnt;
            4:       return wr_cnt;
            default: return 0;
        endcase
    endfunction

    task automatic wait_cnt(input string tag, input int which, input int target, input int budget);
        int i = 0;
        while (get_cnt(which) < target && i < budget) begin
            @(negedge clk); #1;
            i++;
        end
        check(tag, {31'd0, get_cnt(which) >= target}, 32'd1);
    endtask

    task automatic send_word(input logic [NB_DATA-1:0] w);
        int p;
        p = acc_cnt;
        @(posedge clk); #1;
        i_word  = w;
        i_valid = 1'b1;
        wait_cnt("accept", 0, p + 1, 100);
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic pulse_done();
        @(posedge clk); #1 i_uart_tx_done = 1'b1;
        @(posedge clk); #1 i_uart_tx_done = 1'b0;
    endtask

    task automatic pulses(input int count);
        for (int k = 0; k < count; k++) begin
            repeat (9) @(posedge clk);
            pulse_done();
        end
    endtask

    // Full transfer with all tx_done pulses; checks start latency and done timing.
    task automatic run_word(input string tag, input logic [NB_DATA-1:0] w);
        int s, d;
        s = start_cnt;
        d = done_cnt;
        send_word(w);
        wait_cnt({tag, "_start"}, 1, s + 1, 200);
        pulses(N);
        wait_cnt({tag, "_done"}, 2, d + 1, 20);
        check({tag, "_done_latency"}, done_cyc - txd_cyc, 32'd1);
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 i_rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int s, d, e, base, drop_cyc;

        #3;
        check("rst_ready", {31'd0, ready_l}, 32'd1);
        check("rst_outs", {28'd0, wr_l, start_l, done_l, err_l}, 32'd0);
        check("rst_wdata", {24'd0, wdata_l}, 32'd0);
        #20 i_rst = 1'b1;

        // Basic send, timing of writes and tx_start
        i_timeout_cmp = 24'd1000;
        wr_log.delete();
        s = start_cnt;
        send_word(32'hDEADBEEF);
        wait_cnt("t1_start", 1, s + 1, 50);
        check("t1_start_latency", start_cyc - acc_cyc, 32'd5);
        check("t1_wr_count", wr_log.size(), 32'd4);
        check("t1_first_wr", wr_log[0] - acc_cyc, 32'd1);
        check("t1_wr_back_to_back", wr_log[3] - wr_log[0], 32'd3);
        d = done_cnt;
        pulses(N);
        wait_cnt("t1_done", 2, d + 1, 20);
        check("t1_done_latency", done_cyc - txd_cyc, 32'd1);
        @(negedge clk); #1;

        // Byte order (MSB instance sends 01,02,03,04)
        run_word("t2", 32'h01020304);

        // FIFO backpressure after the second byte
        wr_log.delete();
        base = wr_cnt;
        s = start_cnt;
        d = done_cnt;
        send_word(32'hCAFEF00D);
        wait_cnt("bp_two_writes", 4, base + 2, 20);
        @(posedge clk); #1 i_uart_tx_full = 1'b1;
        repeat (5) @(posedge clk);
        #1 i_uart_tx_full = 1'b0;
        drop_cyc = cyc;
        wait_cnt("bp_start", 1, s + 1, 50);
        check("bp_wr_count", wr_log.size(), 32'd4);
        check("bp_third_after_drop", wr_log[2], drop_cyc);
        check("bp_stall_len", wr_log[2] - wr_log[1], 32'd6);
        pulses(N);
        wait_cnt("bp_done", 2, d + 1, 20);
        @(negedge clk); #1;

        // Watchdog expiry after two of four tx_done pulses
        i_timeout_cmp = 24'd100;
        s = start_cnt;
        d = done_cnt;
        e = err_cnt;
        send_word(32'h0BADF00D);
        wait_cnt("wd_start", 1, s + 1, 50);
        pulses(2);
        wait_cnt("wd_error", 3, e + 1, 300);
        check("wd_latency", err_cyc - txd_cyc, 32'd100);
        check("wd_no_done", done_cnt, d);
        @(negedge clk); #1;
        check("wd_ready", {31'd0, ready_l}, 32'd1);

        // Watchdog disabled: block waits indefinitely
        i_timeout_cmp = 24'd0;
        s = start_cnt;
        send_word(32'h13579BDF);
        wait_cnt("wd0_start", 1, s + 1, 50);
        pulses(2);
        repeat (300) @(negedge clk);
        #1;
        check("wd0_no_error", err_cnt, e + 1);
        check("wd0_no_done", done_cnt, d);
        check("wd0_busy", {31'd0, ready_l}, 32'd0);
        do_reset();
        i_timeout_cmp = 24'd1000;

        // Reset mid-LOAD
        base = wr_cnt;
        send_word(32'h11223344);
        wait_cnt("rl_two_writes", 4, base + 2, 20);
        i_rst = 1'b0;
        #1;
        check("rl_ready", {31'd0, ready_l}, 32'd1);
        check("rl_outs", {28'd0, wr_l, start_l, done_l, err_l}, 32'd0);
        check("rl_wdata", {24'd0, wdata_l}, 32'd0);
        check("rl_wdata_msb", {24'd0, wdata_m}, 32'd0);
        repeat (2) @(posedge clk);
        #1 i_rst = 1'b1;
        wr_log.delete();
        run_word("rl_next", 32'h55667788);
        check("rl_next_wr_count", wr_log.size(), 32'd4);

        // Handshake: stray tx_done in IDLE, i_valid held across two words
        pulse_done();
        repeat (3) @(posedge clk);
        base = acc_cnt;
        s = start_cnt;
        d = done_cnt;
        #1 i_word = 32'hA1B2C3D4;
        i_valid = 1'b1;
        wait_cnt("hs_accept1", 0, base + 1, 20);
        @(posedge clk); #1 i_word = 32'h5A6B7C8D;
        wait_cnt("hs_start1", 1, s + 1, 50);
        pulses(N);
        wait_cnt("hs_done1", 2, d + 1, 20);
        check("hs_done1_latency", done_cyc - txd_cyc, 32'd1);
        wait_cnt("hs_accept2", 0, base + 2, 10);
        check("hs_accept_after_done", acc_cyc - done_cyc, 32'd1);
        check("hs_single_accept", acc_cnt, base + 2);
        @(posedge clk); #1 i_valid = 1'b0;
        wait_cnt("hs_start2", 1, s + 2, 50);
        pulses(N);
        wait_cnt("hs_done2", 2, d + 2, 20);
        check("hs_done2_latency", done_cyc - txd_cyc, 32'd1);
        @(negedge clk); #1;

        check("sb_empty_lsb", q_lsb.size(), 32'd0);
        check("sb_empty_msb", q_msb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
